work_dispatcher: RTL and testbench

WORK_DISPATCHER -- requirements
Module: work_dispatcher

---
 rtl/dispatch_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 92 +++++++++
 rtl/work_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_work_dispatcher.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared constants and FSM state types for the work dispatcher and its UART receiver.
package dispatch_pkg;

    localparam int PACKET_BYTES    = 64;
    localparam int NONCE_BYTES     = 4;
    localparam int OVERSAMPLE      = 16;
    localparam int RX_TIMEOUT_BITS = 20;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 UART byte receiver: 2-flop synchronizer, falling-edge start detect,
// start-bit glitch rejection, one-cycle strobes for a good byte or a framing error.
module uart_rx_byte
    import dispatch_pkg::*;
#(
    parameter int TICK_DIV     = 13,
    parameter int SAMPLE_POINT = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frameErr
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PHASE_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0]  TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(OVERSAMPLE - 1);

    rx_state_t          r_state, w_next;
    logic [1:0]         r_sync;
    logic               r_prev;
    logic [TICK_W-1:0]  r_tickDiv;
    logic [PHASE_W-1:0] r_phase;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_shift;
    logic               r_valid;
    logic               r_frameErr;

    logic w_rxs, w_fall, w_tick, w_sample, w_bitEnd;

    assign w_rxs    = r_sync[1];
    assign w_fall   = r_prev & ~w_rxs;
    assign w_tick   = (r_tickDiv == TICK_LAST);
    assign w_sample = w_tick && (r_phase == PHASE_SAMPLE);
    assign w_bitEnd = w_tick && (r_phase == PHASE_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_next = RX_START;
            RX_START: begin
                if (w_sample && w_rxs) w_next = RX_IDLE;
                else if (w_bitEnd)     w_next = RX_DATA;
            end
            RX_DATA:  if (w_bitEnd && r_bitIdx == 3'd7) w_next = RX_STOP;
            RX_STOP:  if (w_sample) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    // Returning to idle at the stop-bit sample point leaves half a bit to catch the next start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_sync     <= 2'b11;
            r_prev     <= 1'b1;
            r_tickDiv  <= '0;
            r_phase    <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_sync     <= {r_sync[0], i_rx};
            r_prev     <= w_rxs;
            r_valid    <= (r_state == RX_STOP) && w_sample && w_rxs;
            r_frameErr <= (r_state == RX_STOP) && w_sample && !w_rxs;
            if (r_state == RX_IDLE) begin
                r_tickDiv <= '0;
                r_phase   <= '0;
                r_bitIdx  <= '0;
            end else if (w_tick) begin
                r_tickDiv <= '0;
                r_phase   <= r_phase + 1'b1;
            end else begin
                r_tickDiv <= r_tickDiv + 1'b1;
            end
            if (r_state == RX_DATA && w_sample) r_shift  <= {w_rxs, r_shift[7:1]};
            if (r_state == RX_DATA && w_bitEnd) r_bitIdx <= r_bitIdx + 1'b1;
        end
    end

    assign o_data     = r_shift;
    assign o_valid    = r_valid;
    assign o_frameErr = r_frameErr;

endmodule

// File: rtl/work_dispatcher.sv
// Sends a 64-byte job {data2, midstate} over an 8N1 UART and collects 4-byte nonce replies.
// The receiver is only built when WORK_DISPATCHER_RX_EN is defined.
module work_dispatcher
    import dispatch_pkg::*;
#(
    parameter int CLOCK        = 25000000,
    parameter int BAUD         = 115200,
    parameter int SAMPLE_POINT = 8
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         tx,
    input  logic         rx,
    output logic [31:0]  nonce,
    output logic         nonce_valid
);

    localparam int BIT_DIV = CLOCK / BAUD;
    localparam int BIT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BYTE_W  = $clog2(PACKET_BYTES);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PACKET_BYTES - 1);

    tx_state_t                     r_txState, w_txNext;
    logic [BIT_W-1:0]              r_bitCnt;
    logic [2:0]                    r_bitIdx, w_bitIdxNext;
    logic [BYTE_W-1:0]             r_byteIdx;
    logic [8*PACKET_BYTES-1:0]     r_packet;
    logic                          r_tx;
    logic                          r_done;
    logic                          w_bitEnd, w_accept, w_done, w_txBit;

    assign w_bitEnd = (r_bitCnt == BIT_LAST);

    // The line level is computed from the next state so tx leaves a flop and the start bit
    // appears on the same cycle busy rises.
    always_comb begin
        w_txNext     = r_txState;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_txBit      = 1'b1;
        w_bitIdxNext = (r_txState == TX_DATA && w_bitEnd) ? r_bitIdx + 3'd1 : r_bitIdx;
        case (r_txState)
            TX_IDLE: begin
                if (start && !r_done) begin
                    w_txNext = TX_START;
                    w_accept = 1'b1;
                end
            end
            TX_START: if (w_bitEnd) w_txNext = TX_DATA;
            TX_DATA:  if (w_bitEnd && r_bitIdx == 3'd7) w_txNext = TX_STOP;
            TX_STOP: begin
                if (w_bitEnd) begin
                    if (r_byteIdx == BYTE_LAST) begin
                        w_txNext = TX_IDLE;
                        w_done   = 1'b1;
                    end else begin
                        w_txNext = TX_START;
                    end
                end
            end
            default: w_txNext = TX_IDLE;
        endcase
        case (w_txNext)
            TX_START: w_txBit = 1'b0;
            TX_DATA:  w_txBit = r_packet[w_bitIdxNext];
            default:  w_txBit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txState <= TX_IDLE;
            r_bitCnt  <= '0;
            r_bitIdx  <= '0;
            r_byteIdx <= '0;
            r_packet  <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_txState <= w_txNext;
            r_tx      <= w_txBit;
            r_done    <= w_done;
            if (w_accept) begin
                r_packet  <= {data2, midstate};
                r_bitCnt  <= '0;
                r_bitIdx  <= '0;
                r_byteIdx <= '0;
            end else if (r_txState != TX_IDLE) begin
                r_bitCnt <= w_bitEnd ? '0 : r_bitCnt + 1'b1;
                r_bitIdx <= w_bitIdxNext;
                if (r_txState == TX_STOP && w_bitEnd) begin
                    r_byteIdx <= r_byteIdx + 1'b1;
                    r_packet  <= r_packet >> 8;
                end
            end
        end
    end

    assign busy = (r_txState != TX_IDLE);
    assign done = r_done;
    assign tx   = r_tx;

`ifdef WORK_DISPATCHER_RX_EN
    localparam int TICK_DIV    = CLOCK / (BAUD * OVERSAMPLE);
    localparam int TIMEOUT_CYC = RX_TIMEOUT_BITS * OVERSAMPLE * TICK_DIV;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    logic [7:0]  w_rxData;
    logic        w_rxValid, w_rxFrameErr;
    logic [1:0]  r_rxCount;
    logic [23:0] r_partial;
    logic [31:0] r_idleCnt;
    logic [31:0] r_nonce;
    logic        r_nonceValid;

    uart_rx_byte #(
        .TICK_DIV     (TICK_DIV),
        .SAMPLE_POINT (SAMPLE_POINT)
    ) u_rxByte (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (rx),
        .o_data     (w_rxData),
        .o_valid    (w_rxValid),
        .o_frameErr (w_rxFrameErr)
    );

    // The timeout only runs while a reply is partially assembled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxCount    <= '0;
            r_partial    <= '0;
            r_idleCnt    <= '0;
            r_nonce      <= '0;
            r_nonceValid <= 1'b0;
        end else begin
            r_nonceValid <= 1'b0;
            if (w_rxFrameErr) begin
                r_rxCount <= '0;
                r_partial <= '0;
                r_idleCnt <= '0;
            end else if (w_rxValid) begin
                r_idleCnt <= '0;
                if (r_rxCount == 2'(NONCE_BYTES - 1)) begin
                    r_nonce      <= {r_partial, w_rxData};
                    r_nonceValid <= 1'b1;
                    r_rxCount    <= '0;
                    r_partial    <= '0;
                end else begin
                    r_partial <= {r_partial[15:0], w_rxData};
                    r_rxCount <= r_rxCount + 1'b1;
                end
            end else if (r_rxCount != '0) begin
                if (r_idleCnt == TIMEOUT_LAST) begin
                    r_rxCount <= '0;
                    r_partial <= '0;
                    r_idleCnt <= '0;
                end else begin
                    r_idleCnt <= r_idleCnt + 1'b1;
                end
            end
        end
    end

    assign nonce       = r_nonce;
    assign nonce_valid = r_nonceValid;
`else
    logic [1:0] w_unused;
    assign w_unused    = {rx, SAMPLE_POINT[0]};
    assign nonce       = '0;
    assign nonce_valid = 1'b0;
`endif

endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized self-checking bench for work_dispatcher against a byte/bit level reference model.
module tb_work_dispatcher;

    localparam int CLK_HZ       = 3_200_000;
    localparam int BAUD_R       = 200_000;
    localparam int BD           = CLK_HZ / BAUD_R;
    localparam int RXB          = CLK_HZ / BAUD_R;
    localparam int TOTAL        = 640 * BD;
    localparam int TIMEOUT_BITS = 20;
`ifdef WORK_DISPATCHER_RX_EN
    localparam bit RX_ON = 1'b1;
`else
    localparam bit RX_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         rx = 1'b1;
    logic [255:0] midstate = '0;
    logic [255:0] data2 = '0;
    logic         busy, done, tx, nonce_valid;
    logic [31:0]  nonce;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] obsQ[$];
    logic [7:0]  mPart[$];
    logic [31:0] expNonce = '0;

    always #5 clk = ~clk;

    work_dispatcher #(
        .CLOCK        (CLK_HZ),
        .BAUD         (BAUD_R),
        .SAMPLE_POINT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .midstate    (midstate),
        .data2       (data2),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .tx          (tx),
        .rx          (rx),
        .nonce       (nonce),
        .nonce_valid (nonce_valid)
    );

    always @(negedge clk) begin
        if (nonce_valid === 1'b1) obsQ.push_back(nonce);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Bit n of the serial packet: 10 bits per byte, start 0, data LSB first, stop 1.
    function automatic logic frameBit(input logic [511:0] pkt, input int n);
        int j;
        int k;
        j = n / 10;
        k = n % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return pkt[8*j + k - 1];
    endfunction

    task automatic applyStimulus(input logic [255:0] ms, input logic [255:0] d2,
                                 input bit midStart, input bit doneStart, input string tag);
        logic [511:0] pkt;
        logic [7:0]   firstByte;
        logic         expTx;
        bit           inPkt;
        int busyErr = 0, busyLen = 0, txErr = 0, doneCnt = 0, doneErr = 0;
        pkt       = {d2, ms};
        firstByte = '0;
        midstate  = ms;
        data2     = d2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < TOTAL + 3*BD; c++) begin
            inPkt = (c < TOTAL);
            expTx = inPkt ? frameBit(pkt, c / BD) : 1'b1;
            if (busy !== inPkt) busyErr++;
            if (busy === 1'b1) busyLen++;
            if (tx !== expTx) txErr++;
            if (done === 1'b1) begin
                doneCnt++;
                if (c != TOTAL) doneErr++;
            end
            if (c / BD >= 1 && c / BD <= 8 && c % BD == BD / 2) firstByte[c/BD - 1] = tx;
            if (midStart && c == 5000) begin
                midstate = rand256();
                data2    = rand256();
                start    = 1'b1;
            end
            if (doneStart && c == TOTAL) start = 1'b1;
            if (c == 5001 || c == TOTAL + 1) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, " busy_window"}, busyErr, 0);
        checkOutput({tag, " busy_cycles"}, busyLen, TOTAL);
        checkOutput({tag, " tx_bits"}, txErr, 0);
        checkOutput({tag, " done_pulses"}, doneCnt, 1);
        checkOutput({tag, " done_timing"}, doneErr, 0);
        checkOutput({tag, " first_byte"}, firstByte, pkt[7:0]);
    endtask

    task automatic sendRxByte(input logic [7:0] b, input bit ok, input int gap);
        if (gap > TIMEOUT_BITS) mPart.delete();
        rx = 1'b1;
        repeat (gap * RXB) @(negedge clk);
        rx = 1'b0;
        repeat (RXB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (RXB) @(negedge clk);
        end
        rx = ok;
        repeat (RXB) @(negedge clk);
        rx = 1'b1;
        if (!ok) begin
            mPart.delete();
        end else begin
            mPart.push_back(b);
            if (mPart.size() == 4) begin
                if (RX_ON) begin
                    expNonce = {mPart[0], mPart[1], mPart[2], mPart[3]};
                    expQ.push_back(expNonce);
                end
                mPart.delete();
            end
        end
    endtask

    task automatic compareRx(input string tag);
        repeat (3 * RXB) @(negedge clk);
        checkOutput({tag, " pulses"}, obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < obsQ.size()) checkOutput($sformatf("%s reply%0d", tag, i), obsQ[i], expQ[i]);
        end
        checkOutput({tag, " nonce"}, nonce, expNonce);
        obsQ.delete();
        expQ.delete();
    endtask

    initial begin
        logic [255:0] pattern;
        int           stray;
        bit           prevBad;
        logic [7:0]   b;
        bit           ok;
        int           gap;

        $display("[TB] reset state");
        repeat (4) @(negedge clk);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst done", done, 1'b0);
        checkOutput("rst tx", tx, 1'b1);
        checkOutput("rst nonce", nonce, 32'h0);
        checkOutput("rst nonce_valid", nonce_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] pattern dispatch");
        for (int i = 0; i < 32; i++) pattern[8*i +: 8] = 8'(i);
        applyStimulus(pattern, '0, 1'b0, 1'b0, "pattern");

        $display("[TB] start while busy");
        applyStimulus(rand256(), rand256(), 1'b1, 1'b0, "busy_start");

        $display("[TB] start on done cycle with concurrent nonce reply");
        fork
            applyStimulus(rand256(), rand256(), 1'b0, 1'b1, "done_start");
            begin
                sendRxByte(8'hDE, 1'b1, 30);
                sendRxByte(8'hAD, 1'b1, 0);
                sendRxByte(8'hBE, 1'b1, 0);
                sendRxByte(8'hEF, 1'b1, 0);
            end
        join
        compareRx("deadbeef");

        $display("[TB] reset mid-packet");
        midstate = rand256();
        data2    = rand256();
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (103 * BD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expNonce = '0;
        mPart.delete();
        checkOutput("midrst tx", tx, 1'b1);
        checkOutput("midrst busy", busy, 1'b0);
        checkOutput("midrst nonce", nonce, expNonce);
        rst   = 1'b0;
        stray = 0;
        for (int c = 0; c < 20 * BD; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) stray++;
        end
        checkOutput("midrst no_resume", stray, 0);

        $display("[TB] framing error");
        sendRxByte(8'h11, 1'b1, 30);
        sendRxByte(8'h22, 1'b1, 0);
        sendRxByte(8'h33, 1'b0, 0);
        sendRxByte(8'h01, 1'b1, 1);
        sendRxByte(8'h02, 1'b1, 0);
        sendRxByte(8'h03, 1'b1, 0);
        sendRxByte(8'h04, 1'b1, 0);
        compareRx("framing");

        $display("[TB] timeout");
        sendRxByte(8'h55, 1'b1, 30);
        sendRxByte(8'h66, 1'b1, 0);
        sendRxByte(8'hAA, 1'b1, 25);
        sendRxByte(8'hBB, 1'b1, 0);
        sendRxByte(8'hCC, 1'b1, 0);
        sendRxByte(8'hDD, 1'b1, 0);
        compareRx("timeout");

        $display("[TB] random reply traffic");
        prevBad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            if (i == 0)
                gap = 30;
            else if (prevBad)
                gap = $urandom_range(1, 4);
            else if ($urandom_range(0, 3) == 0)
                gap = $urandom_range(25, 28);
            else
                gap = $urandom_range(0, 4);
            sendRxByte(b, ok, gap);
            prevBad = !ok;
        end
        compareRx("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
